// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5-8 data bits, none/even/odd parity, 1/1.5/2 stop) with majority-voted sampling.
// rx_done_tick_o pulses one clk after the tick that ends the stop period; no backpressure, results hold until the next frame.
module uart_rx_cfg #(
    parameter int Oversample = 16,
    parameter int SyncStages = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    input  logic       sample_tick_i,
    input  logic [1:0] word_len_i,
    input  logic       parity_en_i,
    input  logic       parity_odd_i,
    input  logic [1:0] stop_bits_i,
    output logic       rx_done_tick_o,
    output logic [7:0] dout_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       break_o
);

    localparam int CW = $clog2(2 * Oversample);
    localparam logic [CW-1:0] C_HALF    = CW'(Oversample / 2 - 1);
    localparam logic [CW-1:0] C_BIT     = CW'(Oversample - 1);
    localparam logic [CW-1:0] C_ONEHALF = CW'(3 * Oversample / 2 - 1);
    localparam logic [CW-1:0] C_TWO     = CW'(2 * Oversample - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [SyncStages-1:0] sync_q;
    logic                  rx_s;
    logic [2:0]            vote_q;
    logic                  bit_v;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            par_acc;
    logic            perr_q;
    logic            ferr_q;
    logic            brk_q;
    logic            armed;
    logic [1:0]      cfg_wl;
    logic            cfg_pen;
    logic            cfg_odd;
    logic [1:0]      cfg_stop;

    logic [2:0]      last_idx;
    logic [CW-1:0]   stop_end;
    logic            stop_chk;
    logic            ferr_n;
    logic            brk_n;
    logic [1:0]      shift_amt;

    // Reset to idle-high so the line is never seen low coming out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
            vote_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], rx_i};
            if (sample_tick_i) begin
                vote_q <= {vote_q[1:0], rx_s};
            end
        end
    end

    assign rx_s  = sync_q[SyncStages-1];
    assign bit_v = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);

    assign last_idx  = {1'b0, cfg_wl} + 3'd4;
    assign stop_end  = (cfg_stop == 2'd0) ? C_BIT : (cfg_stop == 2'd1) ? C_ONEHALF : C_TWO;
    assign stop_chk  = (cnt == C_BIT) || (cfg_stop[1] && (cnt == C_TWO));
    assign ferr_n    = ferr_q | (stop_chk & ~bit_v);
    assign brk_n     = brk_q & ~(stop_chk & bit_v);
    assign shift_amt = 2'd3 - cfg_wl;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            par_acc        <= 1'b0;
            perr_q         <= 1'b0;
            ferr_q         <= 1'b0;
            brk_q          <= 1'b0;
            armed          <= 1'b1;
            cfg_wl         <= '0;
            cfg_pen        <= 1'b0;
            cfg_odd        <= 1'b0;
            cfg_stop       <= '0;
            rx_done_tick_o <= 1'b0;
            dout_o         <= '0;
            parity_err_o   <= 1'b0;
            frame_err_o    <= 1'b0;
            break_o        <= 1'b0;
        end else begin
            rx_done_tick_o <= 1'b0;
            case (state)
                IDLE: begin
                    armed <= armed | rx_s;
                    if (armed && !rx_s) begin
                        state    <= START;
                        cnt      <= '0;
                        cfg_wl   <= word_len_i;
                        cfg_pen  <= parity_en_i;
                        cfg_odd  <= parity_odd_i;
                        cfg_stop <= stop_bits_i;
                    end
                end
                START: begin
                    if (sample_tick_i) begin
                        if (cnt == C_HALF) begin
                            cnt <= '0;
                            if (bit_v) begin
                                state <= IDLE;
                            end else begin
                                state   <= DATA;
                                bit_idx <= '0;
                                par_acc <= 1'b0;
                                perr_q  <= 1'b0;
                                ferr_q  <= 1'b0;
                                brk_q   <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DATA: begin
                    if (sample_tick_i) begin
                        if (cnt == C_BIT) begin
                            cnt     <= '0;
                            shreg   <= {bit_v, shreg[7:1]};
                            par_acc <= par_acc ^ bit_v;
                            brk_q   <= brk_q & ~bit_v;
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == last_idx) begin
                                state <= cfg_pen ? PARITY : STOP;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (sample_tick_i) begin
                        if (cnt == C_BIT) begin
                            cnt    <= '0;
                            perr_q <= (par_acc ^ bit_v) != cfg_odd;
                            brk_q  <= brk_q & ~bit_v;
                            state  <= STOP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                STOP: begin
                    if (sample_tick_i) begin
                        ferr_q <= ferr_n;
                        brk_q  <= brk_n;
                        if (cnt == stop_end) begin
                            // A framing error disarms until the line is seen high again.
                            state          <= IDLE;
                            cnt            <= '0;
                            armed          <= ~ferr_n;
                            rx_done_tick_o <= 1'b1;
                            dout_o         <= shreg >> shift_amt;
                            parity_err_o   <= perr_q;
                            frame_err_o    <= ferr_n;
                            break_o        <= brk_n;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed frames, expected results queued at send time and checked by a monitor on each done pulse.
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       tick;
    logic [1:0] word_len = 2'd3;
    logic       par_en = 1'b0;
    logic       par_odd = 1'b0;
    logic [1:0] stop_bits = 2'd0;
    logic       done;
    logic [7:0] dout;
    logic       perr;
    logic       ferr;
    logic       brk;

    logic [1:0] phase = 2'd0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
        int         lat;
    } exp_t;

    exp_t exp_q[$];

    uart_rx_cfg #(.Oversample(16), .SyncStages(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rx_i          (rx),
        .sample_tick_i (tick),
        .word_len_i    (word_len),
        .parity_en_i   (par_en),
        .parity_odd_i  (par_odd),
        .stop_bits_i   (stop_bits),
        .rx_done_tick_o(done),
        .dout_o        (dout),
        .parity_err_o  (perr),
        .frame_err_o   (ferr),
        .break_o       (brk)
    );

    always #5 clk = ~clk;

    // One sample tick every 4 clocks, so one bit time is 64 clocks.
    always @(posedge clk) begin
        phase <= phase + 2'd1;
        cyc   <= cyc + 1;
    end
    assign tick = (phase == 2'd3);

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("dout", int'(dout), int'(e.d));
                chk("parity_err", int'(perr), int'(e.pe));
                chk("frame_err", int'(ferr), int'(e.fe));
                chk("break", int'(brk), int'(e.bk));
                chk("latency", cyc - start_cyc, e.lat);
            end
        end
    end

    task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe,
                                input logic bk, input int lat);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe; e.bk = bk; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align_phase0();
        do begin
            @(posedge clk);
            #1;
        end while (phase != 2'd0);
    endtask

    // Levels are built per tick period; flip_at inverts the line for one tick period.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen, input bit pbit,
                              input int stop_ticks, input bit stop_lvl, input int flip_at);
        bit lv[$];
        for (int i = 0; i < 16; i++) lv.push_back(1'b0);
        for (int b = 0; b < nbits; b++)
            for (int i = 0; i < 16; i++) lv.push_back(d[b]);
        if (pen)
            for (int i = 0; i < 16; i++) lv.push_back(pbit);
        for (int i = 0; i < stop_ticks; i++) lv.push_back(stop_lvl);
        align_phase0();
        start_cyc = cyc;
        for (int i = 0; i < lv.size(); i++) begin
            rx = (i == flip_at) ? ~lv[i] : lv[i];
            repeat (4) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("pending_frames", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_dout"}, int'(dout), 0);
        chk({tag, "_parity_err"}, int'(perr), 0);
        chk({tag, "_frame_err"}, int'(ferr), 0);
        chk({tag, "_break"}, int'(brk), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(5);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle(20);

        // 8N1 0xA5: 152 ticks = 608 clocks from line fall to done
        expect_frame(8'hA5, 1'b0, 1'b0, 1'b0, 608);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 16, 1'b1, -1);
        wait_drain();
        idle(64);

        // 7E1 0x35 (four ones -> even parity bit 0), then 7O1 with the same wrong parity bit
        word_len = 2'd2; par_en = 1'b1; par_odd = 1'b0;
        expect_frame(8'h35, 1'b0, 1'b0, 1'b0, 608);
        send_frame(8'h35, 7, 1'b1, 1'b0, 16, 1'b1, -1);
        wait_drain();
        idle(64);
        par_odd = 1'b1;
        expect_frame(8'h35, 1'b1, 1'b0, 1'b0, 608);
        send_frame(8'h35, 7, 1'b1, 1'b0, 16, 1'b1, -1);
        wait_drain();
        idle(64);

        // 8N1 with the stop bit low, then a clean frame
        word_len = 2'd3; par_en = 1'b0; par_odd = 1'b0;
        expect_frame(8'h3C, 1'b0, 1'b1, 1'b0, 608);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 16, 1'b0, -1);
        wait_drain();
        idle(128);
        expect_frame(8'h5A, 1'b0, 1'b0, 1'b0, 608);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 16, 1'b1, -1);
        wait_drain();
        idle(64);

        // Line low for 20 bit times: one break frame, no retrigger while held low
        expect_frame(8'h00, 1'b0, 1'b1, 1'b1, 608);
        send_frame(8'h00, 8, 1'b0, 1'b0, 176, 1'b0, -1);
        wait_drain();
        idle(128);
        expect_frame(8'h81, 1'b0, 1'b0, 1'b0, 608);
        send_frame(8'h81, 8, 1'b0, 1'b0, 16, 1'b1, -1);
        wait_drain();
        idle(64);

        // 4-tick glitch is a false start; monitor flags any done
        align_phase0();
        rx = 1'b0;
        idle(16);
        rx = 1'b1;
        idle(640);

        // One inverted tick sample in the middle of data bit 2 (line bit 3) must be voted out
        expect_frame(8'h96, 1'b0, 1'b0, 1'b0, 608);
        send_frame(8'h96, 8, 1'b0, 1'b0, 16, 1'b1, 16 * 3 + 5);
        wait_drain();
        idle(64);

        // Reset in the middle of the data bits
        align_phase0();
        rx = 1'b0;
        idle(64);
        rx = 1'b1;
        idle(64);
        rx = 1'b0;
        idle(40);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midframe_reset");
        rx = 1'b1;
        idle(8);
        rst_n = 1'b1;
        word_len = 2'd0; stop_bits = 2'd2;
        idle(64);

        // 5N2 0x1F: 8 + 80 + 32 = 120 ticks = 480 clocks
        expect_frame(8'h1F, 1'b0, 1'b0, 1'b0, 480);
        send_frame(8'h1F, 5, 1'b0, 1'b0, 32, 1'b1, -1);
        wait_drain();
        idle(128);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Run-time configurable UART receiver; the next generation of the fixed 8N1-style receiver in the adc_ip UART path.
- Adds 5–8 data bits, optional even/odd parity, and 1 / 1.5 / 2 stop bits.
- Adds an input synchroniser, 3-sample majority voting, false-start rejection, and parity, framing and break status.
- Driven by the shared baud generator's sample_tick_i (Oversample ticks per bit); feeds the command/ADC packet layer.

Parameters:
- Oversample, 16, sample ticks per bit; even, ≥8.
- SyncStages, 2, flip-flops in the rx_i synchroniser; ≥2.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- rx_i  input  1  serial line, asynchronous to clk_i; idle high.
- sample_tick_i  input  1  one-clk pulse, Oversample per bit time.
- word_len_i  input  2  data bits: 0→5, 1→6, 2→7, 3→8.
- parity_en_i  input  1  1 = a parity bit follows the data.
- parity_odd_i  input  1  1 = odd parity, 0 = even.
- stop_bits_i  input  2  0→1, 1→1.5, 2→2 stop bits; 3 is treated as 2.
- rx_done_tick_o  output  1  one-clk pulse when a frame completes.
- dout_o  output  8  received data, LSB-first on the line, right-justified; unused upper bits are 0.
- parity_err_o  output  1  parity mismatch in the last frame.
- frame_err_o  output  1  a stop bit was sampled low in the last frame.
- break_o  output  1  the last frame was a break: all data, parity and stop samples low.

Behaviour:
- Reset:
  - Applies asynchronously on rst_ni low, including mid-frame; the partial frame is discarded.
  - All outputs 0, state IDLE, counters 0.
  - Synchroniser and vote registers reset to 1 so no spurious start is seen.
- rx_s: synchronised rx_i.
- Vote register:
  - 3-bit shift of rx_s, updated on each sample_tick_i.
  - bit_v is the majority of the 3 bits.
- Configuration: word_len_i, parity_en_i, parity_odd_i and stop_bits_i are captured in IDLE when the start is detected; changes mid-frame are ignored.
- Tick counter: cnt, width $clog2(2*Oversample), increments only on sample_tick_i.
- State machine:
  - IDLE:
    - If armed and rx_s==0, go to START with cnt=0.
    - armed clears after a frame with frame_err and sets once rx_s==1 is seen, so a held-low line does not retrigger.
  - START:
    - At the tick where cnt==Oversample/2-1 (start-bit centre), evaluate bit_v.
    - bit_v==1 → false start: return to IDLE with no pulse and no status change.
    - bit_v==0 → go to DATA with cnt=0 and bit index 0.
  - DATA:
    - At cnt==Oversample-1, shift bit_v in at the MSB of an 8-bit buffer and reset cnt.
    - After word-length bits, go to PARITY if parity is enabled, else STOP.
    - On capture, the buffer is right-shifted by (8 - word length) so dout_o is right-justified.
  - PARITY:
    - At cnt==Oversample-1, sample bit_v.
    - Error when the XOR of data bits and parity bit ≠ parity_odd.
    - Go to STOP with cnt=0.
  - STOP:
    - Length L = Oversample, 3*Oversample/2, or 2*Oversample ticks.
    - Check bit_v at cnt==Oversample-1; for 2 stop bits, also at 2*Oversample-1.
    - Any low check sets the frame error.
    - At cnt==L-1, go to IDLE and issue done.
- Done:
  - dout_o, parity_err_o, frame_err_o and break_o are registered at the same edge that raises rx_done_tick_o.
  - rx_done_tick_o is high exactly one clk, the cycle after the final stop tick.
  - Status holds until the next done.
  - parity_err_o is 0 when parity is disabled.
  - break_o also implies frame_err_o=1.
- Latency: done rises 1 clk after the tick ending the stop period.
  - 8N1 at Oversample=16: 8+8·16+16 = 152 ticks after start detect.
- A start edge arriving on the same clk as done is accepted (back-to-back frames), provided armed is set.

Test Plan:
- 8N1, send 0xA5 → dout_o=0xA5, one done pulse 152 ticks after start, all errors 0.
- 7E1 send 0x35, then 7O1 with a wrong parity bit → dout_o=0x35 with parity_err_o=0; then parity_err_o=1.
- 8N1 with stop bit forced low → frame_err_o=1, break_o=0; line held high afterwards → next frame decodes normally.
- Line held low for 20 bit times → exactly one done with break_o=1, frame_err_o=1, dout_o=0x00; no further done until the line returns high and a new start arrives.
- 4-tick low glitch, and a single-tick inverted sample inside a data bit → glitch gives no done (false start); flipped sample is voted out, data correct.
- rst_ni pulsed low mid-DATA, then a clean 5N2 frame 0x1F → outputs 0 immediately on reset; next frame gives dout_o=0x1F with a 2-bit stop period.
